// File: rtl/if_prefetch.sv
// Instruction-fetch stage: loadable instruction memory, program counter and a
// FIFO prefetch buffer toward decode. Optional macro IF_PREFETCH_BYPASS_EN.
module if_prefetch #(
  parameter int                 PC_SIZE            = 32,
  parameter int                 WORD_SIZE_IN_BYTES = 4,
  parameter int                 MEM_SIZE_IN_WORDS  = 64,
  parameter int                 FIFO_DEPTH         = 4,
  parameter logic [PC_SIZE-1:0] INSTRUCTION_NOP    = '0
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_start,
  input  logic                                  i_halt,
  input  logic                                  i_enable,
  input  logic                                  i_redirect,
  input  logic [PC_SIZE-1:0]                    i_redirect_pc,
  input  logic                                  i_write_mem,
  input  logic [WORD_SIZE_IN_BYTES*8-1:0]       i_instruction,
  output logic                                  o_full_mem,
  output logic                                  o_empty_mem,
  output logic                                  o_valid,
  output logic [PC_SIZE-1:0]                    o_instruction,
  output logic [PC_SIZE-1:0]                    o_next_seq_pc,
  output logic [PC_SIZE-1:0]                    o_fetch_pc,
  output logic [$clog2(FIFO_DEPTH):0]           o_count
);

  localparam int INSTR_W = WORD_SIZE_IN_BYTES * 8;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int LD_W    = $clog2(MEM_SIZE_IN_WORDS + 1);
  localparam int ADDR_W  = $clog2(MEM_SIZE_IN_WORDS);
  localparam logic [PC_SIZE-1:0] PC_INC = PC_SIZE'(WORD_SIZE_IN_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_e;

  state_e              state_q;
  logic [PC_SIZE-1:0]  fetch_pc_q, fetch_pc_d;
  logic [LD_W-1:0]     load_cnt_q;
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [INSTR_W-1:0]  mem_q        [MEM_SIZE_IN_WORDS];
  logic [INSTR_W-1:0]  fifo_instr_q [FIFO_DEPTH];
  logic [PC_SIZE-1:0]  fifo_npc_q   [FIFO_DEPTH];

  logic [PC_SIZE-1:0]  fetch_word;
  logic [INSTR_W-1:0]  fetch_data;
  logic [PC_SIZE-1:0]  fetch_npc;
  logic                redirect_act, mem_we, fifo_full, fifo_empty;
  logic                can_fetch, bypass, valid, pop, fetch, push, fifo_pop;
  logic [INSTR_W-1:0]  head_instr;
  logic [PC_SIZE-1:0]  head_npc;

  assign fetch_word   = fetch_pc_q / PC_INC;
  assign fetch_data   = mem_q[fetch_word[ADDR_W-1:0]];
  assign fetch_npc    = fetch_pc_q + PC_INC;
  assign redirect_act = i_redirect && (state_q != S_IDLE);
  assign mem_we       = !i_reset && (state_q == S_IDLE) && i_write_mem && !o_full_mem;
  assign fifo_full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty   = (count_q == '0);

  // Fetch stage: a word is fetchable only inside the loaded region, never wrapping.
  assign can_fetch = (state_q == S_RUN) && !i_halt && !redirect_act &&
                     (fetch_word < PC_SIZE'(load_cnt_q));

`ifdef IF_PREFETCH_BYPASS_EN
  assign bypass = fifo_empty && can_fetch;
`else
  assign bypass = 1'b0;
`endif

  assign valid      = !redirect_act && (!fifo_empty || bypass);
  assign head_instr = bypass ? fetch_data : fifo_instr_q[rd_ptr_q];
  assign head_npc   = bypass ? fetch_npc  : fifo_npc_q[rd_ptr_q];
  assign pop        = valid && i_enable;
  assign fetch      = can_fetch && (!fifo_full || pop);
  // A bypassed word consumed the same cycle never occupies a FIFO slot.
  assign push       = fetch && !(bypass && pop);
  assign fifo_pop   = pop && !bypass;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    if (redirect_act) begin
      fetch_pc_d = i_redirect_pc;
      count_d    = '0;
    end else begin
      if (fetch) fetch_pc_d = fetch_npc;
      count_d = count_q + CNT_W'(push) - CNT_W'(fifo_pop);
    end
  end

  // Control state: reset applies here only.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= '0;
      load_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE:   if (i_start) state_q <= S_RUN;
        S_RUN:    if (i_halt)  state_q <= S_HALTED;
        S_HALTED: state_q <= S_HALTED;
        default:  state_q <= S_IDLE;
      endcase
      if (mem_we) load_cnt_q <= load_cnt_q + LD_W'(1);
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      if (redirect_act) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push)     wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (fifo_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Storage: instruction memory and FIFO payload, never cleared.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[load_cnt_q[ADDR_W-1:0]] <= i_instruction;
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= fetch_data;
      fifo_npc_q[wr_ptr_q]   <= fetch_npc;
    end
  end

  assign o_valid       = valid;
  assign o_instruction = valid ? PC_SIZE'(head_instr) : INSTRUCTION_NOP;
  assign o_next_seq_pc = valid ? head_npc : '0;
  assign o_fetch_pc    = fetch_pc_q;
  assign o_count       = count_q;
  assign o_full_mem    = (load_cnt_q == LD_W'(MEM_SIZE_IN_WORDS));
  assign o_empty_mem   = (load_cnt_q == '0);

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: vector table, directed sequences and
// randomized traffic against a queue-based reference model.
module tb_if_prefetch;

`ifdef IF_PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0;

  logic        i_clk = 1'b0, i_reset = 1'b1, i_start = 1'b0, i_halt = 1'b0;
  logic        i_enable = 1'b0, i_redirect = 1'b0, i_write_mem = 1'b0;
  logic [31:0] i_redirect_pc = '0, i_instruction = '0;
  logic        o_full_mem, o_empty_mem, o_valid;
  logic [31:0] o_instruction, o_next_seq_pc, o_fetch_pc;
  logic [2:0]  o_count;

  if_prefetch dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_halt(i_halt),
    .i_enable(i_enable), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .i_write_mem(i_write_mem), .i_instruction(i_instruction),
    .o_full_mem(o_full_mem), .o_empty_mem(o_empty_mem), .o_valid(o_valid),
    .o_instruction(o_instruction), .o_next_seq_pc(o_next_seq_pc),
    .o_fetch_pc(o_fetch_pc), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit rst; bit start; bit halt; bit en; bit redir;
    logic [31:0] rpc; bit wr; logic [31:0] wdata;
  } stim_t;

  typedef struct { logic [31:0] instr; logic [31:0] npc; } ent_t;

  int n_cmp = 0, n_err = 0;

  // Reference model state
  logic [31:0] m_mem [64];
  int          m_load;
  logic [31:0] m_pc;
  int          m_state;  // 0 idle, 1 run, 2 halted
  ent_t        m_q[$];

  // Values observed during the most recent step
  logic        s_valid;
  logic [31:0] s_instr, s_npc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic stim_t S(bit rst, bit start, bit halt, bit en, bit redir,
                              logic [31:0] rpc, bit wr, logic [31:0] wdata);
    stim_t s;
    s.rst = rst; s.start = start; s.halt = halt; s.en = en; s.redir = redir;
    s.rpc = rpc; s.wr = wr; s.wdata = wdata;
    return s;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pc = '0; m_load = 0; m_q.delete();
  endtask

  // One clock cycle: drive at the falling edge, check just after, advance model at rising edge.
  task automatic step(input stim_t s);
    bit redir_act, can_fetch, byp, e_valid, pop, fetch;
    ent_t head;
    i_reset = s.rst; i_start = s.start; i_halt = s.halt; i_enable = s.en;
    i_redirect = s.redir; i_redirect_pc = s.rpc; i_write_mem = s.wr; i_instruction = s.wdata;
    #1;
    redir_act = s.redir && (m_state != 0);
    can_fetch = (m_state == 1) && !s.halt && !redir_act && ((m_pc / 4) < m_load);
    byp       = BYP && (m_q.size() == 0) && can_fetch;
    e_valid   = !redir_act && (m_q.size() != 0 || byp);
    if (byp) head = '{m_mem[m_pc / 4], m_pc + 4};
    else if (m_q.size() != 0) head = m_q[0];
    else head = '{32'h0, 32'h0};
    s_valid = o_valid; s_instr = o_instruction; s_npc = o_next_seq_pc;
    chk("valid", {31'b0, o_valid}, {31'b0, e_valid});
    chk("instruction", o_instruction, e_valid ? head.instr : NOP);
    chk("next_seq_pc", o_next_seq_pc, e_valid ? head.npc : 32'h0);
    chk("fetch_pc", o_fetch_pc, m_pc);
    chk("count", {29'b0, o_count}, m_q.size());
    chk("full_mem", {31'b0, o_full_mem}, {31'b0, m_load == 64});
    chk("empty_mem", {31'b0, o_empty_mem}, {31'b0, m_load == 0});
    @(posedge i_clk);
    if (s.rst) model_reset();
    else begin
      pop   = e_valid && s.en;
      fetch = can_fetch && (m_q.size() < 4 || pop);
      if (m_state == 0 && s.wr && m_load < 64) begin
        m_mem[m_load] = s.wdata;
        m_load++;
      end
      if (redir_act) begin
        m_q.delete();
        m_pc = s.rpc;
      end else begin
        if (pop && !byp) void'(m_q.pop_front());
        if (fetch && !(byp && pop)) m_q.push_back('{m_mem[m_pc / 4], m_pc + 4});
        if (fetch) m_pc = m_pc + 4;
      end
      if (m_state == 0 && s.start) m_state = 1;
      else if (m_state == 1 && s.halt) m_state = 2;
    end
    @(negedge i_clk);
  endtask

  task automatic idle(input bit en);
    step(S(0, 0, 0, en, 0, 0, 0, 0));
  endtask

  task automatic do_reset();
    step(S(1, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic load(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) step(S(0, 0, 0, 0, 0, 0, 1, base + i));
  endtask

  task automatic chk_reset_outputs(input string tag);
    i_reset = 0; i_start = 0; i_halt = 0; i_enable = 0; i_redirect = 0; i_write_mem = 0;
    #1;
    chk({tag, "_valid"}, {31'b0, o_valid}, 32'h0);
    chk({tag, "_instr"}, o_instruction, NOP);
    chk({tag, "_npc"}, o_next_seq_pc, 32'h0);
    chk({tag, "_fpc"}, o_fetch_pc, 32'h0);
    chk({tag, "_count"}, {29'b0, o_count}, 32'h0);
    chk({tag, "_empty"}, {31'b0, o_empty_mem}, 32'h1);
    chk({tag, "_full"}, {31'b0, o_full_mem}, 32'h0);
  endtask

  typedef struct {
    bit start; bit wr; logic [31:0] wdata;
    bit ev; logic [31:0] ei; logic [31:0] enp; logic [31:0] efpc;
  } vec_t;

  function automatic vec_t V(bit start, bit wr, logic [31:0] wdata,
                             bit ev, logic [31:0] ei, logic [31:0] enp, logic [31:0] efpc);
    vec_t v;
    v.start = start; v.wr = wr; v.wdata = wdata; v.ev = ev; v.ei = ei; v.enp = enp; v.efpc = efpc;
    return v;
  endfunction

  initial begin
    vec_t tbl[9];
    int lat, got, k;
    logic [31:0] fpc_hold;

    // Power-up reset
    @(negedge i_clk);
    i_reset = 1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    model_reset();
    chk_reset_outputs("reset");

    // Scenario 1: three words streamed with decode always ready
    tbl[0] = V(0, 1, 32'h11, 0, NOP, 0, 0);
    tbl[1] = V(0, 1, 32'h22, 0, NOP, 0, 0);
    tbl[2] = V(0, 1, 32'h33, 0, NOP, 0, 0);
    tbl[3] = V(1, 0, 0,      0, NOP, 0, 0);
    if (BYP) begin
      tbl[4] = V(0, 0, 0, 1, 32'h11, 4,  0);
      tbl[5] = V(0, 0, 0, 1, 32'h22, 8,  4);
      tbl[6] = V(0, 0, 0, 1, 32'h33, 12, 8);
      tbl[7] = V(0, 0, 0, 0, NOP,    0,  12);
      tbl[8] = V(0, 0, 0, 0, NOP,    0,  12);
    end else begin
      tbl[4] = V(0, 0, 0, 0, NOP,    0,  0);
      tbl[5] = V(0, 0, 0, 1, 32'h11, 4,  4);
      tbl[6] = V(0, 0, 0, 1, 32'h22, 8,  8);
      tbl[7] = V(0, 0, 0, 1, 32'h33, 12, 12);
      tbl[8] = V(0, 0, 0, 0, NOP,    0,  12);
    end
    for (int i = 0; i < 9; i++) begin
      logic [31:0] fpc_now;
      fpc_now = o_fetch_pc;
      step(S(0, tbl[i].start, 0, 1, 0, 0, tbl[i].wr, tbl[i].wdata));
      chk($sformatf("tbl%0d_valid", i), {31'b0, s_valid}, {31'b0, tbl[i].ev});
      chk($sformatf("tbl%0d_instr", i), s_instr, tbl[i].ei);
      chk($sformatf("tbl%0d_npc", i), s_npc, tbl[i].enp);
      chk($sformatf("tbl%0d_fpc", i), fpc_now, tbl[i].efpc);
    end

    // Scenario 2: stalled decode fills the FIFO, release drains in order
    do_reset();
    load(8, 32'h100);
    step(S(0, 1, 0, 0, 0, 0, 0, 0));
    repeat (10) idle(0);
    chk("stall_count", {29'b0, o_count}, 32'd4);
    chk("stall_fpc", o_fetch_pc, 32'd16);
    for (int i = 0; i < 8; i++) begin
      idle(1);
      chk($sformatf("drain%0d_valid", i), {31'b0, s_valid}, 32'h1);
      chk($sformatf("drain%0d_instr", i), s_instr, 32'h100 + i);
    end

    // Scenario 3: redirect with three buffered entries
    do_reset();
    load(8, 32'h200);
    step(S(0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10 && m_q.size() != 3; i++) idle(0);
    chk("redir_prefill", {29'b0, o_count}, 32'd3);
    step(S(0, 0, 0, 1, 1, 32'h14, 0, 0));
    chk("redir_cycle_valid", {31'b0, s_valid}, 32'h0);
    lat = 0;
    idle(1);
    while (!s_valid && lat < 4) begin
      lat++;
      idle(1);
    end
    chk("redir_latency", lat, BYP ? 32'd0 : 32'd1);
    chk("redir_first_instr", s_instr, 32'h205);
    chk("redir_first_npc", s_npc, 32'h18);
    idle(1);
    chk("redir_second_instr", s_instr, 32'h206);
    chk("redir_second_npc", s_npc, 32'h1C);

    // Scenario 4: memory overfill, then read the whole image back
    do_reset();
    for (int i = 0; i < 66; i++) begin
      step(S(0, 0, 0, 0, 0, 0, 1, 32'h1000 + i));
      if (i == 62) chk("full_after_63", {31'b0, o_full_mem}, 32'h0);
      if (i == 63) chk("full_after_64", {31'b0, o_full_mem}, 32'h1);
    end
    step(S(0, 1, 0, 1, 0, 0, 0, 0));
    got = 0;
    for (int i = 0; i < 70; i++) begin
      idle(1);
      if (s_valid) begin
        chk($sformatf("image_word%0d", got), s_instr, 32'h1000 + got);
        got++;
      end
    end
    chk("image_words", got, 32'd64);
    chk("image_end_fpc", o_fetch_pc, 32'd256);

    // Scenario 5: halt with two entries buffered, then reset mid-run
    do_reset();
    load(8, 32'h300);
    step(S(0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10 && m_q.size() != 2; i++) idle(0);
    step(S(0, 0, 1, 0, 0, 0, 0, 0));
    k = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (s_valid) begin
        chk($sformatf("halt_drain%0d", k), s_instr, 32'h300 + k);
        k++;
      end
    end
    chk("halt_drained", k, 32'd2);
    chk("halt_fpc", o_fetch_pc, 32'd8);
    fpc_hold = o_fetch_pc;
    repeat (3) idle(1);
    chk("halt_fpc_frozen", o_fetch_pc, fpc_hold);

    do_reset();
    load(4, 32'h400);
    step(S(0, 1, 0, 0, 0, 0, 0, 0));
    repeat (3) idle(0);
    do_reset();
    chk_reset_outputs("midrun_reset");

    // Scenario 6: randomized traffic against the model
    for (int ep = 0; ep < 6; ep++) begin
      int n;
      do_reset();
      n = $urandom_range(0, 24);
      for (int i = 0; i < n; i++) step(S(0, 0, 0, 0, 0, 0, 1, $urandom));
      step(S(0, 1, 0, 1, 0, 0, 0, 0));
      for (int c = 0; c < 150; c++) begin
        stim_t s;
        s.rst   = ($urandom_range(0, 149) == 0);
        s.start = ($urandom_range(0, 9) == 0);
        s.halt  = ($urandom_range(0, 39) == 0);
        s.en    = ($urandom_range(0, 9) < 7);
        s.redir = ($urandom_range(0, 11) == 0);
        s.rpc   = $urandom_range(0, 30) * 4;
        s.wr    = ($urandom_range(0, 3) == 0);
        s.wdata = $urandom;
        step(s);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Parametrised instruction-fetch stage with a loadable instruction memory, a program counter and a FIFO prefetch buffer between fetch and decode. It fetches ahead of the decode stage while decode is stalled, flushes the buffer on control-flow redirects and keeps the halt/start protocol of the pipeline. It sits between the debug loader (memory writes) and the IF/ID register.

## Interface
- `PC_SIZE`, 32, width of PC and instruction buses.
- `WORD_SIZE_IN_BYTES`, 4, instruction size in bytes and PC increment.
- `MEM_SIZE_IN_WORDS`, 64, instruction memory depth.
- `FIFO_DEPTH`, 4, prefetch entries; power of two, ≥2.

- `i_clk` in 1, single clock; all state updates on the rising edge.
- `i_reset` in 1, synchronous, active-high.
- `i_start` in 1, leave IDLE and begin fetching.
- `i_halt` in 1, stop fetching (enter HALTED).
- `i_enable` in 1, decode ready; pops the head entry when `o_valid`.
- `i_redirect` in 1, taken branch/jump: flush and refetch.
- `i_redirect_pc` in PC_SIZE, redirect target (byte address).
- `i_write_mem` in 1, append `i_instruction` to memory.
- `i_instruction` in WORD_SIZE_IN_BYTES*8, load data.
- `o_full_mem` out 1, load count == MEM_SIZE_IN_WORDS.
- `o_empty_mem` out 1, load count == 0.
- `o_valid` out 1, head entry valid.
- `o_instruction` out PC_SIZE, head instruction, `INSTRUCTION_NOP` when not valid.
- `o_next_seq_pc` out PC_SIZE, fetch address of head + WORD_SIZE_IN_BYTES.
- `o_fetch_pc` out PC_SIZE, next address to fetch.
- `o_count` out $clog2(FIFO_DEPTH)+1, buffered entries.

## Operation
- States: IDLE (reset), RUN, HALTED. IDLE→RUN on `i_start`; RUN→HALTED on `i_halt`; HALTED exits only by reset.
- Loading: in IDLE only, `i_write_mem` writes at the load pointer, which then increments; ignored when `o_full_mem` or outside IDLE. Memory read is combinational, indexed by fetch_pc / WORD_SIZE_IN_BYTES.
- Fetch: in RUN, when the FIFO is not full or is being popped this cycle, and fetch_pc/WORD_SIZE_IN_BYTES < load count, push {mem[word], fetch_pc+W} and fetch_pc += W. If the PC is beyond the loaded region, there is no push; the stage waits, with no wrap.
- Pop: `o_valid && i_enable && !i_redirect`. Simultaneous push and pop when full are allowed; the count is unchanged.
- Redirect (RUN or HALTED): the FIFO is emptied, fetch_pc ← `i_redirect_pc`, and `o_valid` is forced 0 in that cycle. Redirect has priority over push and pop.
- HALTED: no pushes; buffered entries still drain through pops.
- Simultaneous `i_halt` and `i_redirect`: the redirect is applied and the state becomes HALTED.
- Reset: fetch_pc=0, FIFO empty, load count=0 and state IDLE. Memory contents are not cleared. Reset overrides every other input.
- Reset outputs: `o_valid`=0, `o_instruction`=`INSTRUCTION_NOP`, `o_next_seq_pc`=0, `o_fetch_pc`=0, `o_count`=0, `o_empty_mem`=1, `o_full_mem`=0.

## Timing
- `i_start` sampled at edge N puts the stage in RUN in cycle N+1. The first push happens at edge N+1, and `o_valid` is 1 in cycle N+2.
- After that, throughput is one instruction per cycle while `i_enable`=1.
- With `i_enable`=0, the FIFO fills in FIFO_DEPTH cycles and fetch_pc then stops.
- Redirect sampled at edge R gives the first target instruction valid in cycle R+2.
- The memory write at edge W is fetchable from cycle W+1.

## Configuration
- `IF_PREFETCH_BYPASS_EN`: defined means that when the FIFO is empty and a fetch is possible, the fetched word drives `o_instruction`/`o_next_seq_pc` combinationally with `o_valid`=1. If it is popped in that cycle, it is not written to the FIFO.
  - Start latency becomes N+1 and redirect latency becomes R+1.
- Undefined: all instructions pass through the FIFO, with the latencies given above.

## Test plan
- Reset, load 3 words 0x11,0x22,0x33, start, `i_enable`=1 → `o_instruction` 0x11,0x22,0x33 in consecutive cycles; `o_next_seq_pc` 4,8,12; then `o_valid`=0 and `o_fetch_pc`=12.
- Load 8 words, start, `i_enable`=0 for 10 cycles → `o_count`=4, `o_fetch_pc`=16. Release → words 0..7 in order with no gaps.
- Load 8 words, start, redirect to 0x14 while the FIFO holds 3 entries → `o_valid`=0 that cycle, then word 5 (pc+4=0x18) and word 6.
- Write MEM_SIZE_IN_WORDS+2 words → `o_full_mem`=1 after 64 writes; extra writes are ignored and words 0..63 are unchanged.
- Assert `i_halt` with 2 entries buffered → both drain, then `o_valid`=0 and `o_fetch_pc` is frozen. Reset mid-run → all outputs return to reset values the next cycle.
- With `IF_PREFETCH_BYPASS_EN` defined, repeat scenario 1 → 0x11 is valid in the first RUN cycle.
